// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction sequencer: FSM encoding and master byte timing.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_TX        = 3'd2,
    ST_RX        = 3'd3,
    ST_GAP       = 3'd4
  } spi_state_e;

  localparam int SPI_BYTE_CYCLES = 16;

endpackage

// File: rtl/spi_byte_fifo.sv
// 8-bit first-word-fall-through FIFO; rd_data always shows the head entry while count is non-zero.
module spi_byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [7:0]    rd_data,
  input  logic          rd_en,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign wr_ready = (count != CW'(DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_en && (count != '0);
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Frame sequencer in front of the byte-level SPI master: tx_len bytes out, then rx_len bytes in, one cs frame.
// Handshakes: a transfer happens on the edge where valid and ready are both high; valid must not depend on ready.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 5,
  parameter int CS_GAP     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [LEN_W-1:0] cmd_tx_len,
  input  logic [LEN_W-1:0] cmd_rx_len,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             cmd_err,
  output logic [7:0]       rx_byte,
  output logic             rx_valid,
  output logic             busy,
  output logic             xfer_done,
  output logic             spi_tx_en,
  output logic             spi_rx_en,
  output logic [7:0]       spi_data_in,
  input  logic [7:0]       spi_data_out,
  input  logic             spi_tx_done,
  input  logic             spi_rx_done,
  output spi_state_e       dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = $clog2(CS_GAP) + 1;

  spi_state_e       state;
  logic [LEN_W-1:0] tx_len_q;
  logic [LEN_W-1:0] rx_len_q;
  logic [LEN_W-1:0] tx_rem;
  logic [LEN_W-1:0] rx_rem;
  logic [GW-1:0]    gap_cnt;
  logic [7:0]       fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_pop;
  logic             data_ready;

  assign dbg_state  = state;
  assign data_ready = (LEN_W'(fifo_count) >= tx_len_q);

  always_comb begin
    fifo_pop = 1'b0;
    if (state == ST_WAIT_DATA && tx_len_q != '0 && data_ready) fifo_pop = 1'b1;
    if (state == ST_TX && spi_tx_done && tx_rem > LEN_W'(1))   fifo_pop = 1'b1;
  end

  spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (tx_data),
    .wr_valid (tx_valid),
    .wr_ready (tx_ready),
    .rd_data  (fifo_head),
    .rd_en    (fifo_pop),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tx_len_q    <= '0;
      rx_len_q    <= '0;
      tx_rem      <= '0;
      rx_rem      <= '0;
      gap_cnt     <= '0;
      cmd_ready   <= 1'b1;
      cmd_err     <= 1'b0;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      xfer_done   <= 1'b0;
      spi_tx_en   <= 1'b0;
      spi_rx_en   <= 1'b0;
      spi_data_in <= '0;
    end else begin
      cmd_err   <= 1'b0;
      rx_valid  <= 1'b0;
      xfer_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            tx_len_q <= cmd_tx_len;
            rx_len_q <= cmd_rx_len;
            if (cmd_tx_len > LEN_W'(FIFO_DEPTH)) begin
              cmd_err <= 1'b1;
            end else begin
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
              if (cmd_tx_len == '0 && cmd_rx_len == '0) begin
                state     <= ST_GAP;
                xfer_done <= 1'b1;
                gap_cnt   <= '0;
              end else begin
                state <= ST_WAIT_DATA;
              end
            end
          end
        end
        // The whole TX payload must be queued first so the master never runs dry mid-frame.
        ST_WAIT_DATA: begin
          if (data_ready) begin
            if (tx_len_q != '0) begin
              spi_data_in <= fifo_head;
              spi_tx_en   <= 1'b1;
              tx_rem      <= tx_len_q;
              state       <= ST_TX;
            end else begin
              spi_rx_en <= 1'b1;
              rx_rem    <= rx_len_q;
              state     <= ST_RX;
            end
          end
        end
        ST_TX: begin
          if (spi_tx_done) begin
            tx_rem <= tx_rem - 1'b1;
            if (tx_rem > LEN_W'(1)) begin
              spi_data_in <= fifo_head;
            end else if (rx_len_q != '0) begin
              spi_tx_en <= 1'b0;
              spi_rx_en <= 1'b1;
              rx_rem    <= rx_len_q;
              state     <= ST_RX;
            end else begin
              spi_tx_en <= 1'b0;
              xfer_done <= 1'b1;
              gap_cnt   <= '0;
              state     <= ST_GAP;
            end
          end
        end
        // The master clears data_out once both enables drop, so capture on the done edge itself.
        ST_RX: begin
          if (spi_rx_done) begin
            rx_byte  <= spi_data_out;
            rx_valid <= 1'b1;
            rx_rem   <= rx_rem - 1'b1;
            if (rx_rem == LEN_W'(1)) begin
              spi_rx_en <= 1'b0;
              xfer_done <= 1'b1;
              gap_cnt   <= '0;
              state     <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(CS_GAP - 1)) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: behavioural byte-level SPI master plus MISO slave table, scoreboard queues for MOSI/RX bytes.
module tb_spi_xfer_ctrl;
  import spi_pkg::*;

  localparam int FIFO_DEPTH = 16;
  localparam int LEN_W      = 5;
  localparam int CS_GAP     = 2;

  logic             clk;
  logic             rst;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [LEN_W-1:0] cmd_tx_len;
  logic [LEN_W-1:0] cmd_rx_len;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_err;
  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic             busy;
  logic             xfer_done;
  logic             spi_tx_en;
  logic             spi_rx_en;
  logic [7:0]       spi_data_in;
  logic [7:0]       spi_data_out;
  logic             spi_tx_done;
  logic             spi_rx_done;
  spi_state_e       dbg_state;

  logic             cs_n;
  logic             spur_tx = 1'b0;
  logic             spur_rx = 1'b0;
  logic [3:0]       bit_cnt = '0;
  int               rx_idx = 0;
  logic [7:0]       slave_mem [8];

  logic [7:0]       rx_exp_q[$];
  logic [7:0]       mosi_exp_q[$];
  int               done_exp = 0;
  int               done_seen = 0;
  int               err_exp = 0;
  int               err_seen = 0;
  int               n_checks = 0;
  int               n_fail = 0;

  spi_xfer_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEN_W      (LEN_W),
    .CS_GAP     (CS_GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .cmd_tx_len   (cmd_tx_len),
    .cmd_rx_len   (cmd_rx_len),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_err      (cmd_err),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .busy         (busy),
    .xfer_done    (xfer_done),
    .spi_tx_en    (spi_tx_en),
    .spi_rx_en    (spi_rx_en),
    .spi_data_in  (spi_data_in),
    .spi_data_out (spi_data_out),
    .spi_tx_done  (spi_tx_done),
    .spi_rx_done  (spi_rx_done),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Master model: one byte every SPI_BYTE_CYCLES cycles while an enable is high; cs_n follows the enables.
  assign cs_n         = !(spi_tx_en || spi_rx_en);
  assign spi_tx_done  = (spi_tx_en && bit_cnt == 4'(SPI_BYTE_CYCLES - 1)) || spur_tx;
  assign spi_rx_done  = (spi_rx_en && bit_cnt == 4'(SPI_BYTE_CYCLES - 1)) || spur_rx;
  assign spi_data_out = spi_rx_en ? slave_mem[rx_idx[2:0]] : 8'h00;

  always @(posedge clk) begin
    bit_cnt <= (spi_tx_en || spi_rx_en) ? bit_cnt + 1'b1 : 4'd0;
    if (spi_rx_en && bit_cnt == 4'(SPI_BYTE_CYCLES - 1)) rx_idx <= rx_idx + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected bytes whenever the DUT presents one
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        n_checks++;
        if (rx_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rx_unexpected: got 0x%0h, expected no byte", rx_byte);
        end else begin
          logic [7:0] e;
          e = rx_exp_q.pop_front();
          if (rx_byte !== e) begin
            n_fail++;
            $display("FAIL rx_byte: got 0x%0h, expected 0x%0h", rx_byte, e);
          end
        end
      end
      if (spi_tx_en && bit_cnt == 4'd0) begin
        n_checks++;
        if (mosi_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL mosi_unexpected: got 0x%0h, expected no byte", spi_data_in);
        end else begin
          logic [7:0] e;
          e = mosi_exp_q.pop_front();
          if (spi_data_in !== e) begin
            n_fail++;
            $display("FAIL mosi_byte: got 0x%0h, expected 0x%0h", spi_data_in, e);
          end
        end
      end
      if (xfer_done) done_seen++;
      if (cmd_err)   err_seen++;
    end
  end

  // Driver tasks: all are entered and left just after a falling edge
  task automatic push_byte(input logic [7:0] b, input bit expect_sent);
    int g = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    if (expect_sent) mosi_exp_q.push_back(b);
    while (!tx_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("push_timeout", 32'(g < 1000), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic send_cmd(input int t, input int r);
    int g = 0;
    cmd_tx_len = LEN_W'(t);
    cmd_rx_len = LEN_W'(r);
    cmd_valid  = 1'b1;
    while (!cmd_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("cmd_timeout", 32'(g < 1000), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (t > FIFO_DEPTH) err_exp++;
    else done_exp++;
  endtask

  task automatic run_frame(input string tag, input int exp_tx, input int exp_rx);
    int  tx_c = 0;
    int  rx_c = 0;
    int  gap_c = 0;
    int  g = 0;
    bit  seen_en = 0;
    bit  seen_done = 0;
    bit  brk = 0;
    bit  ovl = 0;
    while (g < 2000) begin
      if (spi_tx_en) tx_c++;
      if (spi_rx_en) rx_c++;
      if (spi_tx_en && spi_rx_en) ovl = 1;
      if (spi_tx_en || spi_rx_en) seen_en = 1;
      else if (seen_en && !seen_done && !xfer_done) brk = 1;
      if (xfer_done) seen_done = 1;
      if (seen_done) begin
        if (!busy) break;
        gap_c++;
      end
      @(negedge clk);
      g++;
    end
    check({tag, "_timeout"},  32'(g < 2000), 32'd1);
    check({tag, "_tx_cyc"},   32'(tx_c), 32'(exp_tx));
    check({tag, "_rx_cyc"},   32'(rx_c), 32'(exp_rx));
    check({tag, "_gap_cyc"},  32'(gap_c), 32'(CS_GAP));
    check({tag, "_cs_break"}, 32'(brk), 32'd0);
    check({tag, "_overlap"},  32'(ovl), 32'd0);
  endtask

  initial begin
    bit bad;
    int g;
    slave_mem[0] = 8'h5A;
    slave_mem[1] = 8'hC3;
    for (int i = 2; i < 8; i++) slave_mem[i] = 8'(8'h70 + i);
    rst        = 1'b1;
    tx_data    = '0;
    tx_valid   = 1'b0;
    cmd_tx_len = '0;
    cmd_rx_len = '0;
    cmd_valid  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_ready",  32'(tx_ready), 32'd1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_outputs",   32'({busy, xfer_done, cmd_err, rx_valid, spi_tx_en, spi_rx_en}), 32'd0);
    check("rst_state",     32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Two-byte write-only frame
    push_byte(8'hA5, 1);
    push_byte(8'h3C, 1);
    send_cmd(2, 0);
    run_frame("t2", 32, 0);

    // Write one, read two: tx_en to rx_en handoff with cs held low
    push_byte(8'h9F, 1);
    rx_exp_q.push_back(8'h5A);
    rx_exp_q.push_back(8'hC3);
    send_cmd(1, 2);
    run_frame("t3", 16, 32);

    // Command waits for the third byte before starting
    push_byte(8'h11, 1);
    push_byte(8'h22, 1);
    send_cmd(3, 0);
    bad = 0;
    repeat (4) begin
      if (spi_tx_en || spi_rx_en || dbg_state != ST_WAIT_DATA) bad = 1;
      @(negedge clk);
    end
    check("t4_wait_hold", 32'(bad), 32'd0);
    push_byte(8'h33, 1);
    check("t4_tx_not_yet", 32'(spi_tx_en), 32'd0);
    @(negedge clk);
    check("t4_tx_start", 32'(spi_tx_en), 32'd1);
    run_frame("t4", 48, 0);

    // Oversized command, empty command, spurious dones
    send_cmd(17, 0);
    check("t5_err_pulse", 32'(cmd_err), 32'd1);
    check("t5_err_idle",  32'({busy, spi_tx_en, spi_rx_en}), 32'd0);
    @(negedge clk);
    check("t5_err_once",  32'(cmd_err), 32'd0);
    send_cmd(0, 0);
    run_frame("t5z", 0, 0);
    spur_tx = 1'b1;
    spur_rx = 1'b1;
    @(negedge clk);
    spur_tx = 1'b0;
    spur_rx = 1'b0;
    @(negedge clk);
    check("t5_spurious", 32'({busy, rx_valid, spi_tx_en, spi_rx_en}), 32'd0);

    // Fill FIFO; 17th push held until the frame pops one
    for (int i = 0; i < FIFO_DEPTH; i++) push_byte(8'(8'h80 + 3 * i), 1);
    check("t5_full", 32'(tx_ready), 32'd0);
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    mosi_exp_q.push_back(8'hEE);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_ready) bad = 1;
    end
    check("t5_full_hold", 32'(bad), 32'd0);
    cmd_tx_len = LEN_W'(FIFO_DEPTH);
    cmd_rx_len = '0;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    done_exp++;
    fork
      run_frame("t5full", 16 * FIFO_DEPTH, 0);
      begin
        g = 0;
        while (!tx_ready && g < 1000) begin
          @(negedge clk);
          g++;
        end
        check("t5_held_push", 32'(g < 1000), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    send_cmd(1, 0);
    run_frame("t5last", 16, 0);

    // Reset in the middle of an RX phase; 0x55 left queued must be discarded
    push_byte(8'h44, 1);
    push_byte(8'h55, 0);
    send_cmd(1, 3);
    done_exp--;
    g = 0;
    while (!spi_rx_en && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("t1_rx_reached", 32'(g < 1000), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t1_enables",  32'({spi_tx_en, spi_rx_en}), 32'd0);
    check("t1_cs_n",     32'(cs_n), 32'd1);
    check("t1_ready",    32'({cmd_ready, tx_ready}), 32'd3);
    check("t1_state",    32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t1_busy", 32'(busy), 32'd0);
    push_byte(8'h66, 1);
    send_cmd(1, 0);
    run_frame("t1post", 16, 0);

    // Final scoreboard reconciliation
    repeat (4) @(negedge clk);
    check("rx_q_drained",   32'(rx_exp_q.size()), 32'd0);
    check("mosi_q_drained", 32'(mosi_exp_q.size()), 32'd0);
    check("done_count",     32'(done_seen), 32'(done_exp));
    check("err_count",      32'(err_seen), 32'(err_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
